// File: rtl/wb_regfile.sv
// Writeback stage and rv32 integer register file: load extraction, result select, commit, instret.
// Optional WB_BYPASS_EN: a read of the register being committed returns wb_result_o in the same cycle.
package wb_regfile_pkg;
  typedef enum logic [1:0] {
    RESULT_SRC_ALU = 2'd0,
    RESULT_SRC_MEM = 2'd1,
    RESULT_SRC_PC4 = 2'd2,
    RESULT_SRC_CSR = 2'd3
  } resultSrc_e;
endpackage

module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_valid_i,
  input  logic            reg_wr_en_i,
  input  resultSrc_e      result_src_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] mem_rd_data_i,
  input  logic [2:0]      load_funct3_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] pc_plus_4_i,
  input  logic [XLEN-1:0] csr_rd_data_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] wb_result_o,
  output logic [63:0]     instret_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [63:0]     instret_q, instret_d;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;
  logic            commit;

  // Memory returns the aligned word; pick the lane addressed by the low address bits.
  always_comb begin
    case (alu_result_i[1:0])
      2'd0: ld_byte = mem_rd_data_i[7:0];
      2'd1: ld_byte = mem_rd_data_i[15:8];
      2'd2: ld_byte = mem_rd_data_i[23:16];
      default: ld_byte = mem_rd_data_i[31:24];
    endcase
    ld_half = alu_result_i[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];
    case (load_funct3_i)
      3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_val = mem_rd_data_i;
    endcase
  end

  always_comb begin
    case (result_src_i)
      RESULT_SRC_MEM: wb_result_o = ld_val;
      RESULT_SRC_PC4: wb_result_o = pc_plus_4_i;
      RESULT_SRC_CSR: wb_result_o = csr_rd_data_i;
      default:        wb_result_o = alu_result_i;
    endcase
  end

  assign commit = wb_valid_i && reg_wr_en_i && (rd_i != 5'd0);

  always_comb begin
    instret_d = instret_q;
    if (wb_valid_i) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[rd_i] <= wb_result_o;
    end
  end

`ifdef WB_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = commit && !rst_i && (rs1_addr_i == rd_i);
  assign byp2 = commit && !rst_i && (rs2_addr_i == rd_i);
`endif

  // x0 is never written after reset, but force zero anyway so reads don't depend on it.
  always_comb begin
    rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : regs_q[rs1_addr_i];
    rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : regs_q[rs2_addr_i];
`ifdef WB_BYPASS_EN
    if (byp1) rs1_data_o = wb_result_o;
    if (byp2) rs2_data_o = wb_result_o;
`endif
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes model-predicted outputs, monitor checks them mid-cycle.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst, wb_valid, reg_wr_en;
  resultSrc_e  result_src;
  logic [31:0] alu_result, mem_rd_data, pc_plus_4, csr_rd_data;
  logic [2:0]  load_funct3;
  logic [4:0]  rd, rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_result;
  logic [63:0] instret;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk_i(clk), .rst_i(rst), .wb_valid_i(wb_valid), .reg_wr_en_i(reg_wr_en),
    .result_src_i(result_src), .alu_result_i(alu_result), .mem_rd_data_i(mem_rd_data),
    .load_funct3_i(load_funct3), .rd_i(rd), .pc_plus_4_i(pc_plus_4),
    .csr_rd_data_i(csr_rd_data), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(rs1_data), .rs2_data_o(rs2_data), .wb_result_o(wb_result),
    .instret_o(instret)
  );

  typedef struct {
    bit rst, vld, we;
    logic [1:0] src;
    logic [31:0] alu, mem, pc4, csr;
    logic [2:0] f3;
    logic [4:0] rd, a1, a2;
  } stim_t;

  typedef struct {
    logic [31:0] wbr, r1, r2;
    logic [63:0] ir;
  } exp_t;

  exp_t scb[$];
  int n_cmp = 0, n_bad = 0;

  // Reference model: architectural state as plain arrays
  logic [31:0]     m_regs [32];
  longint unsigned m_ir;

  function automatic logic [31:0] m_load(logic [31:0] mem, logic [31:0] alu, logic [2:0] f3);
    int unsigned off = alu & 3;
    logic [31:0] b = (mem >> (8 * off)) & 32'hFF;
    logic [31:0] h = (mem >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b ^ 32'h80) - 32'h80;
      3'b001:  return (h ^ 32'h8000) - 32'h8000;
      3'b100:  return b;
      3'b101:  return h;
      default: return mem;
    endcase
  endfunction

  function automatic logic [31:0] m_result(stim_t s);
    case (s.src)
      2'd1:    return m_load(s.mem, s.alu, s.f3);
      2'd2:    return s.pc4;
      2'd3:    return s.csr;
      default: return s.alu;
    endcase
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a, stim_t s);
    if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (!s.rst && s.vld && s.we && s.rd != 0 && a == s.rd) return m_result(s);
`endif
    return m_regs[a];
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.vld = 0; s.we = 0; s.src = 2'd0;
    s.alu = 0; s.mem = 0; s.pc4 = 0; s.csr = 0; s.f3 = 3'b010;
    s.rd = 0; s.a1 = 0; s.a2 = 0;
    return s;
  endfunction

  task automatic apply(stim_t s);
    rst = s.rst; wb_valid = s.vld; reg_wr_en = s.we; result_src = resultSrc_e'(s.src);
    alu_result = s.alu; mem_rd_data = s.mem; pc_plus_4 = s.pc4; csr_rd_data = s.csr;
    load_funct3 = s.f3; rd = s.rd; rs1_addr = s.a1; rs2_addr = s.a2;
  endtask

  task automatic drive(stim_t s);
    exp_t e;
    @(posedge clk); #1;
    apply(s);
    e.wbr = m_result(s);
    e.r1  = m_read(s.a1, s);
    e.r2  = m_read(s.a2, s);
    e.ir  = m_ir;
    scb.push_back(e);
    if (s.rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_ir = 0;
    end else begin
      if (s.vld) m_ir = m_ir + 1;
      if (s.vld && s.we && s.rd != 0) m_regs[s.rd] = e.wbr;
    end
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle with a pushed entry is checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        check("wb_result", {32'h0, wb_result}, {32'h0, e.wbr});
        check("rs1_data",  {32'h0, rs1_data},  {32'h0, e.r1});
        check("rs2_data",  {32'h0, rs2_data},  {32'h0, e.r2});
        check("instret",   instret,            e.ir);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    logic [4:0] last_rd;
    foreach (m_regs[i]) m_regs[i] = 0;
    m_ir = 0;
    s = idle(); s.rst = 1; apply(s);
    repeat (2) @(posedge clk);

    // Reset state
    s = idle(); s.a1 = 5; s.a2 = 31; drive(s);

    // Preload x5, then reset with a write to x6 presented
    s = idle(); s.vld = 1; s.we = 1; s.rd = 5; s.alu = 32'h1234; drive(s);
    s = idle(); s.a1 = 5; drive(s);
    s = idle(); s.rst = 1; s.vld = 1; s.we = 1; s.rd = 6; s.alu = 32'h5555; s.a1 = 5; drive(s);
    s = idle(); s.a1 = 5; s.a2 = 6; drive(s);

    // Load extraction
    s = idle(); s.vld = 1; s.we = 1; s.src = 2'd1; s.mem = 32'h80FF7F01;
    s.rd = 10; s.alu = 3; s.f3 = 3'b000; drive(s);
    s.rd = 11; s.alu = 1; s.f3 = 3'b100; drive(s);
    s.rd = 12; s.alu = 2; s.f3 = 3'b001; drive(s);
    s.rd = 13; s.alu = 0; s.f3 = 3'b101; drive(s);
    s.rd = 14; s.alu = 2; s.f3 = 3'b010; drive(s);
    s = idle(); s.a1 = 10; s.a2 = 11; drive(s);
    s.a1 = 12; s.a2 = 13; drive(s);
    s.a1 = 14; s.a2 = 0; drive(s);

    // x0 protection
    s = idle(); s.vld = 1; s.we = 1; s.rd = 0; s.alu = 32'hDEADBEEF; drive(s);
    s = idle(); drive(s);

    // Same-cycle read of a write, then next cycle
    s = idle(); s.vld = 1; s.we = 1; s.rd = 7; s.src = 2'd3; s.csr = 32'hA5A5A5A5;
    s.a1 = 7; s.a2 = 7; drive(s);
    s = idle(); s.a2 = 7; drive(s);

    // Bubbles and counting
    s = idle(); s.rst = 1; drive(s);
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.vld = (i % 2 == 0); s.we = (i % 3 != 0);
      s.rd = 5'(16 + i); s.src = 2'd2; s.pc4 = 32'h1000 + 4 * i;
      s.a1 = 5'(16 + i - 1); s.a2 = 5'(16 + i - 2); drive(s);
    end
    for (int i = 0; i < 10; i += 2) begin
      s = idle(); s.a1 = 5'(16 + i); s.a2 = 5'(17 + i); drive(s);
    end

    // Counter wrap: preset the counter to all ones during an idle cycle
    @(posedge clk); #1;
    s = idle(); apply(s);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_ir = 64'hFFFF_FFFF_FFFF_FFFF;
    s = idle(); s.vld = 1; drive(s);
    s = idle(); drive(s);

    // Randomized traffic with occasional mid-stream reset
    last_rd = 1;
    for (int i = 0; i < 300; i++) begin
      s = idle();
      s.rst = ($urandom_range(0, 39) == 0);
      s.vld = $urandom_range(0, 3) != 0;
      s.we  = $urandom_range(0, 3) != 0;
      s.src = 2'($urandom_range(0, 3));
      s.alu = $urandom(); s.mem = $urandom(); s.pc4 = $urandom(); s.csr = $urandom();
      s.f3  = 3'($urandom_range(0, 7));
      s.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.a1  = ($urandom_range(0, 1) != 0) ? s.rd : last_rd;
      s.a2  = 5'($urandom_range(0, 31));
      drive(s);
      last_rd = s.rd;
    end
    s = idle(); drive(s);

    for (int i = 0; i < 10 && scb.size() > 0; i++) @(negedge clk);
    if (scb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending expected 0", scb.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
